// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID-register update selector
// used by the IF/ID stage and its hazard decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // What the IF/ID register does on the next edge, highest priority first
  typedef enum logic [1:0] {
    UPD_FLUSH,
    UPD_HOLD,
    UPD_SQUASH,
    UPD_LOAD
  } id_update_e;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/if_id_hazard_stage_if.sv
// Fetch/EX-facing signal bundle of the IF/ID hazard stage; the stage
// itself is the slave, the fetch unit and EX stage form the master side.
interface if_id_hazard_stage_if;
  import mips_pkg::*;

  logic [31:0] instr_IF;
  logic [31:0] PC_4_IF;
  logic        branch_taken_EX;
  logic        memread_EX;
  logic [4:0]  rt_EX;

  logic [31:0] instr_ID;
  logic [31:0] PC_4_ID;
  logic        valid_ID;
  logic        jSig_ID;
  logic        PCWrite;
  logic [31:0] PC_last;
  logic        bubble_EX;

  modport master (
    output instr_IF, PC_4_IF, branch_taken_EX, memread_EX, rt_EX,
    input  instr_ID, PC_4_ID, valid_ID, jSig_ID, PCWrite, PC_last, bubble_EX
  );

  modport slave (
    input  instr_IF, PC_4_IF, branch_taken_EX, memread_EX, rt_EX,
    output instr_ID, PC_4_ID, valid_ID, jSig_ID, PCWrite, PC_last, bubble_EX
  );

endinterface

// File: rtl/if_id_hazard_stage_hazard_detect.sv
// Purely combinational ID decode: which source registers the ID
// instruction reads, whether it is a jump, and load-use detection.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       valid,
  input  logic       memread_EX,
  input  logic [4:0] rt_EX,
  output logic       load_use,
  output logic       is_jump
);

  logic uses_rs;
  logic uses_rt;

  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    case (op)
      OP_J, OP_JAL, OP_LUI:     uses_rs = 1'b0;
      OP_RTYPE, OP_SW, OP_BEQ:  uses_rt = 1'b1;
      default: ;
    endcase
  end

  // $0 is never a real dependency, and bubbles must not alias an opcode
  assign is_jump  = valid & is_jump_op(op);
  assign load_use = valid & memread_EX & (rt_EX != 5'd0) &
                    ((uses_rs & (rs == rt_EX)) | (uses_rt & (rt == rt_EX)));

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with ID-stage jump squash, branch flush and
// load-use stall, plus saturating stall/flush debug counters.
module if_id_hazard_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  if_id_hazard_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  logic        load_use;
  logic        is_jump;
  logic        stall;
  logic        jump_sig;
  id_update_e  upd;
  logic        flush_inc;

  hazard_detect u_hazard_detect (
    .op         (instr_q[31:26]),
    .rs         (instr_q[25:21]),
    .rt         (instr_q[20:16]),
    .valid      (valid_q),
    .memread_EX (bus.memread_EX),
    .rt_EX      (bus.rt_EX),
    .load_use   (load_use),
    .is_jump    (is_jump)
  );

  // A taken branch overrides both the stall and the jump redirect
  assign stall    = load_use & ~bus.branch_taken_EX;
  assign jump_sig = is_jump & ~bus.branch_taken_EX;

  always_comb begin
    upd = UPD_LOAD;
    if (bus.branch_taken_EX) upd = UPD_FLUSH;
    else if (stall)          upd = UPD_HOLD;
    else if (jump_sig)       upd = UPD_SQUASH;
  end

  // Only a real squashed instruction counts as a flush, not a bubble
  assign flush_inc = ((upd == UPD_FLUSH) & valid_q) | (upd == UPD_SQUASH);

  // Flush and squash both park the slot's PC+4 so PC_last names it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      case (upd)
        UPD_FLUSH, UPD_SQUASH: begin
          instr_q <= NOP_INSTR;
          pc4_q   <= bus.PC_4_IF;
          valid_q <= 1'b0;
        end
        UPD_HOLD: ;
        default: begin
          instr_q <= bus.instr_IF;
          pc4_q   <= bus.PC_4_IF;
          valid_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((upd == UPD_HOLD) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1))         flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.instr_ID  = instr_q;
  assign bus.PC_4_ID   = pc4_q;
  assign bus.valid_ID  = valid_q;
  assign bus.jSig_ID   = jump_sig;
  assign bus.PCWrite   = ~stall;
  assign bus.PC_last   = pc4_q - 32'd4;
  assign bus.bubble_EX = stall | bus.branch_taken_EX;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Randomized and directed bench for if_id_hazard_stage, checked every
// cycle against a behavioural pipeline model kept in the bench.
module tb_if_id_hazard_stage;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = 16;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] ADD_9_8_1 = 32'h0101_4820;
  localparam logic [31:0] ADD_9_0_0 = 32'h0000_4820;
  localparam logic [31:0] J_INSTR   = 32'h0800_0C10;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  if_id_hazard_stage_if bus();

  if_id_hazard_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;
  int          m_stalls;
  int          m_flushes;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic bit reads_rs(input logic [5:0] op);
    return !(op inside {OP_J, OP_JAL, OP_LUI});
  endfunction

  function automatic bit reads_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_SW, OP_BEQ};
  endfunction

  function automatic bit exp_load_use();
    logic [5:0] op;
    op = m_instr[31:26];
    if (!m_valid || !bus.memread_EX || bus.rt_EX == 5'd0) return 1'b0;
    return (reads_rs(op) && m_instr[25:21] == bus.rt_EX) ||
           (reads_rt(op) && m_instr[20:16] == bus.rt_EX);
  endfunction

  function automatic bit exp_stall();
    return exp_load_use() && !bus.branch_taken_EX;
  endfunction

  function automatic bit exp_jump();
    return m_valid && (m_instr[31:26] inside {OP_J, OP_JAL}) && !bus.branch_taken_EX;
  endfunction

  // Behavioural model of the ID slot and counters
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_instr <= 32'h0; m_pc4 <= RESET_PC; m_valid <= 1'b0;
      m_stalls <= 0; m_flushes <= 0;
    end else if (bus.branch_taken_EX) begin
      m_instr <= 32'h0; m_valid <= 1'b0; m_pc4 <= bus.PC_4_IF;
      if (m_valid) m_flushes <= sat(m_flushes + 1);
    end else if (exp_stall()) begin
      m_stalls <= sat(m_stalls + 1);
    end else if (exp_jump()) begin
      m_instr <= 32'h0; m_valid <= 1'b0; m_pc4 <= bus.PC_4_IF;
      m_flushes <= sat(m_flushes + 1);
    end else begin
      m_instr <= bus.instr_IF; m_pc4 <= bus.PC_4_IF; m_valid <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("instr_ID",  bus.instr_ID,  m_instr);
    checkOutput("PC_4_ID",   bus.PC_4_ID,   m_pc4);
    checkOutput("valid_ID",  32'(bus.valid_ID),  32'(m_valid));
    checkOutput("jSig_ID",   32'(bus.jSig_ID),   32'(exp_jump()));
    checkOutput("PCWrite",   32'(bus.PCWrite),   32'(!exp_stall()));
    checkOutput("bubble_EX", 32'(bus.bubble_EX), 32'(exp_stall() || bus.branch_taken_EX));
    checkOutput("PC_last",   bus.PC_last,   m_pc4 - 32'd4);
    checkOutput("stall_cnt", 32'(stall_cnt), m_stalls);
    checkOutput("flush_cnt", 32'(flush_cnt), m_flushes);
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc4,
                               input logic br, input logic mr, input logic [4:0] rt);
    bus.instr_IF        = instr;
    bus.PC_4_IF         = pc4;
    bus.branch_taken_EX = br;
    bus.memread_EX      = mr;
    bus.rt_EX           = rt;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] random_instr();
    logic [5:0] ops [8];
    logic [31:0] w;
    ops = '{OP_RTYPE, OP_J, OP_JAL, OP_LUI, OP_SW, OP_BEQ, OP_LW, 6'b001000};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 7)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit expired");
  end

  initial begin
    logic [31:0] pc;
    reset = 1'b1;
    applyStimulus(32'h0, RESET_PC + 32'd4, 1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_instr_ID", bus.instr_ID, 32'h0);
    checkOutput("rst_PC_4_ID", bus.PC_4_ID, 32'h0000_3000);
    checkOutput("rst_PC_last", bus.PC_last, 32'h0000_2FFC);
    checkOutput("rst_PCWrite", 32'(bus.PCWrite), 32'd1);

    applyStimulus(ADD_9_8_1, 32'h3004, 1'b0, 1'b0, 5'd0);
    nextCycle();
    checkOutput("s1_instr_ID", bus.instr_ID, ADD_9_8_1);
    checkOutput("s1_PC_last", bus.PC_last, 32'h0000_3000);

    applyStimulus(ADD_9_0_0, 32'h3008, 1'b0, 1'b1, 5'd8);
    checkOutput("lu_PCWrite", 32'(bus.PCWrite), 32'd0);
    checkOutput("lu_bubble", 32'(bus.bubble_EX), 32'd1);
    nextCycle();
    checkOutput("lu_hold", bus.instr_ID, ADD_9_8_1);
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    applyStimulus(ADD_9_0_0, 32'h3008, 1'b0, 1'b0, 5'd0);
    checkOutput("lu_release", 32'(bus.PCWrite), 32'd1);
    nextCycle();
    checkOutput("lu_advance", bus.instr_ID, ADD_9_0_0);

    applyStimulus(J_INSTR, 32'h300C, 1'b0, 1'b1, 5'd0);
    checkOutput("rt0_PCWrite", 32'(bus.PCWrite), 32'd1);
    nextCycle();
    checkOutput("j_in_ID", bus.instr_ID, J_INSTR);

    applyStimulus(ADD_9_8_1, 32'h3010, 1'b0, 1'b0, 5'd0);
    checkOutput("j_jSig", 32'(bus.jSig_ID), 32'd1);
    nextCycle();
    checkOutput("j_squash", bus.instr_ID, 32'h0);
    checkOutput("j_valid", 32'(bus.valid_ID), 32'd0);
    checkOutput("j_flush_cnt", 32'(flush_cnt), 32'd1);

    applyStimulus(ADD_9_8_1, 32'h3014, 1'b0, 1'b0, 5'd0);
    checkOutput("bub_jSig", 32'(bus.jSig_ID), 32'd0);
    nextCycle();

    applyStimulus(ADD_9_0_0, 32'h3018, 1'b1, 1'b1, 5'd8);
    checkOutput("br_PCWrite", 32'(bus.PCWrite), 32'd1);
    checkOutput("br_bubble", 32'(bus.bubble_EX), 32'd1);
    nextCycle();
    checkOutput("br_instr_ID", bus.instr_ID, 32'h0);
    checkOutput("br_PC_4_ID", bus.PC_4_ID, 32'h3018);
    checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd2);
    checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd1);

    applyStimulus(ADD_9_8_1, 32'h301C, 1'b0, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(ADD_9_0_0, 32'h3020, 1'b0, 1'b1, 5'd8);
    nextCycle();
    checkOutput("mid_stall_cnt", 32'(stall_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_instr", bus.instr_ID, 32'h0);
    checkOutput("mid_rst_PC_4", bus.PC_4_ID, 32'h0000_3000);
    checkOutput("mid_rst_PCWrite", 32'(bus.PCWrite), 32'd1);
    checkOutput("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(ADD_9_8_1, 32'h3004, 1'b0, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(ADD_9_0_0, 32'h3008, 1'b0, 1'b1, 5'd8);
    repeat ((1 << CNT_W) + 3) @(posedge clk);
    #1;
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    checkOutput("sat_PCWrite", 32'(bus.PCWrite), 32'd0);

    pc = 32'h3008;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(random_instr(), pc, 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
      pc += 32'd4;
      nextCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_stage.md
Name: if_id_hazard_stage

Overview:
IF/ID pipeline register fused with the ID-stage control-hazard and load-use hazard logic of the 5-stage MIPS pipeline. It latches the fetched instruction and its PC+4 from the fetch unit, and decodes jumps in ID. It generates PCWrite, PC_last and jSig_ID back to the fetch unit and inserts bubbles into ID/EX. It also keeps saturating stall and flush counters for performance debug.

Parameters:
RESET_PC, 32'h0000_3000, fetch reset address; PC_last resets to RESET_PC-4.
CNT_W, 16, width of the stall and flush counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
instr_IF  in  32  instruction from fetch
PC_4_IF  in  32  PC+4 from fetch
branch_taken_EX  in  1  nPC_sel_EX & zero_EX from EX; branch redirect this cycle
memread_EX  in  1  instruction in EX is lw
rt_EX  in  5  destination register of the instruction in EX
instr_ID  out  32  latched instruction
PC_4_ID  out  32  latched PC+4
valid_ID  out  1  instr_ID is a real (non-squashed) instruction
jSig_ID  out  1  valid j/jal in ID (combinational)
PCWrite  out  1  0 = freeze fetch PC (combinational)
PC_last  out  32  PC_4_ID-4, address of the instruction in ID (combinational)
bubble_EX  out  1  zero ID/EX control this cycle (combinational)
stall_cnt  out  CNT_W  cycles stalled, saturating
flush_cnt  out  CNT_W  instructions flushed, saturating

Behaviour:
- Reset (async, any time, including mid-stall): instr_ID=0, PC_4_ID=RESET_PC, valid_ID=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow from these values: jSig_ID=0, PCWrite=1, bubble_EX=0, PC_last=RESET_PC-4.
- ID decode: op=instr_ID[31:26], rs=[25:21], rt=[20:16].
  - is_jump = valid_ID & (op==6'b000010 | op==6'b000011).
  - uses_rs = op not in {j, jal, lui(001111)}.
  - uses_rt = op in {R-type 000000, sw 101011, beq 000100}.
- load_use = valid_ID & memread_EX & rt_EX!=0 & ((uses_rs & rs==rt_EX) | (uses_rt & rt==rt_EX)).
- Combinational outputs:
  - stall = load_use & ~branch_taken_EX.
  - PCWrite = ~stall.
  - bubble_EX = stall | branch_taken_EX.
  - jSig_ID = is_jump & ~branch_taken_EX.
- Register update at posedge clk. Priority, highest first:
  1. branch_taken_EX: load instr_ID=0, valid_ID=0 (flush). PC_4_ID takes PC_4_IF. flush_cnt += valid_ID (the squashed ID instruction is counted; a bubble is not).
  2. stall: hold instr_ID, PC_4_ID, valid_ID. stall_cnt += 1.
  3. jSig_ID: load instr_ID=0, valid_ID=0 (squash the slot fetched after the jump). flush_cnt += 1.
  4. else: load instr_ID=instr_IF, PC_4_ID=PC_4_IF, valid_ID=1.
- Counters saturate at all-ones and never wrap.
- Load-use latency: exactly one stall cycle per lw. On the next cycle lw has left EX, so memread_EX drops.
- Branch taken and load-use in the same cycle: the branch wins, with no stall and no stall_cnt increment.
- A jump never stalls, because uses_rs and uses_rt are both 0 for j/jal.
- Bubbles (valid_ID=0) never raise load_use or jSig_ID, even when instr_ID bits alias an opcode.

Decomposition:
- Shared package mips_pkg: opcode constants OP_RTYPE, OP_J, OP_JAL, OP_LUI, OP_SW, OP_BEQ, OP_LW; NOP_INSTR = 32'h0.
- One natural sub-module: hazard_detect, the purely combinational load_use/uses_rs/uses_rt decode. The pipeline register and counters stay in the top.

Test Plan:
- Reset mid-stall: assert reset while stall=1 -> instr_ID=0, PC_4_ID=32'h3000, PCWrite=1, stall_cnt=0 immediately (asynchronous).
- Load-use: EX lw $8 (memread_EX=1, rt_EX=8), ID add $9,$8,$1 -> PCWrite=0 and bubble_EX=1 for exactly 1 cycle, instr_ID held, stall_cnt 0->1; next cycle add advances.
- rt_EX=0: memread_EX=1, rt_EX=0, ID uses $0 -> no stall, PCWrite=1.
- Jump: instr_IF=32'h0800_0C10 (j) enters ID -> jSig_ID=1 for one cycle; next cycle instr_ID=0, valid_ID=0, flush_cnt=1.
- Branch taken with load-use in the same cycle -> no stall, instr_ID=0 next cycle, flush_cnt+1, stall_cnt unchanged.
- Saturation: force 2^CNT_W+3 stall cycles -> stall_cnt stays at 16'hFFFF.
